// File: rtl/sipo_pkg.sv
// Shared constants and types for the serial-to-parallel deserialiser.
package sipo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        SIPO_LSB_FIRST = 1'b0,
        SIPO_MSB_FIRST = 1'b1
    } sipo_order_e;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input / parallel output bundle for sipo_deser; the slave modport is the deserialiser side.
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             serial_in;
    logic             serial_valid;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;

    modport master (
        output serial_in,
        output serial_valid,
        output out_ready,
        input  parallel_out,
        input  out_valid,
        input  bit_count,
        input  overrun
    );

    modport slave (
        input  serial_in,
        input  serial_valid,
        input  out_ready,
        output parallel_out,
        output out_valid,
        output bit_count,
        output overrun
    );

endinterface

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register; reports a load that arrives while the entry is
// occupied and not being drained.
module sipo_out_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] parallel_out_o,
    output logic             out_valid_o,
    output logic             full_drop_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             free;

    always_comb begin
        // Pass-through: a word leaving on this edge frees the slot for the incoming one.
        free        = !valid_q || out_ready_i;
        full_drop_o = load_i && !free;
        data_d      = data_q;
        valid_d     = valid_q;
        if (load_i && free) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign parallel_out_o = data_q;
    assign out_valid_o    = valid_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserialiser: shift register, bit counter and sticky overrun flag in front
// of a one-word output holding register.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic        clk,
    input logic        rst,
    input logic        flush,
    sipo_deser_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovr_q, ovr_d;
    logic             complete;
    logic             full_drop;

    always_comb begin
        // The word including the incoming bit, used both as next shift state and on completion.
        if (MSB_FIRST) begin
            word = {shift_q[WIDTH-2:0], bus.serial_in};
        end else begin
            word = {bus.serial_in, shift_q[WIDTH-1:1]};
        end
        complete = bus.serial_valid && (count_q == CNT_W'(WIDTH - 1));
        shift_d  = shift_q;
        count_d  = count_q;
        if (bus.serial_valid) begin
            shift_d = word;
            count_d = complete ? '0 : count_q + 1'b1;
        end
        ovr_d = ovr_q | full_drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else if (flush) begin
            shift_q <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .load_i         (complete),
        .load_data_i    (word),
        .out_ready_i    (bus.out_ready),
        .parallel_out_o (bus.parallel_out),
        .out_valid_o    (bus.out_valid),
        .full_drop_o    (full_drop)
    );

    assign bus.bit_count = count_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: an MSB-first and an LSB-first instance share one stimulus stream and are
// compared every cycle against a bit-list model, plus directed literal expectations.
module tb_sipo_deser;
    import sipo_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(W)) bus_m ();
    sipo_deser_if #(.WIDTH(W)) bus_l ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(SIPO_MSB_FIRST)) dut_m (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus_m.slave)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(SIPO_LSB_FIRST)) dut_l (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus_l.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model state: list of bits received so far in the current word, plus the holding slot.
    bit           mbits[$];
    bit           m_valid;
    bit [W-1:0]   m_word_m;
    bit [W-1:0]   m_word_l;
    bit           m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbits.delete();
        m_valid  = 1'b0;
        m_word_m = '0;
        m_word_l = '0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_edge(input bit sv, input bit si, input bit rdy, input bit fl);
        bit         done;
        bit [W-1:0] wm;
        bit [W-1:0] wl;
        if (fl) begin
            model_reset();
            return;
        end
        done = 1'b0;
        wm   = '0;
        wl   = '0;
        if (sv) begin
            mbits.push_back(si);
            if (mbits.size() == W) begin
                for (int i = 0; i < int'(W); i++) begin
                    wm[W-1-i] = mbits[i];
                    wl[i]     = mbits[i];
                end
                mbits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid  = 1'b1;
                m_word_m = wm;
                m_word_l = wl;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        check("cmp_count_m", 32'(bus_m.bit_count), mbits.size());
        check("cmp_count_l", 32'(bus_l.bit_count), mbits.size());
        check("cmp_valid_m", 32'(bus_m.out_valid), 32'(m_valid));
        check("cmp_valid_l", 32'(bus_l.out_valid), 32'(m_valid));
        check("cmp_ovr_m", 32'(bus_m.overrun), 32'(m_ovr));
        check("cmp_ovr_l", 32'(bus_l.overrun), 32'(m_ovr));
        if (m_valid) begin
            check("cmp_word_m", 32'(bus_m.parallel_out), 32'(m_word_m));
            check("cmp_word_l", 32'(bus_l.parallel_out), 32'(m_word_l));
        end
    end

    task automatic step(input bit sv, input bit si, input bit rdy, input bit fl);
        bus_m.serial_valid = sv;
        bus_l.serial_valid = sv;
        bus_m.serial_in    = si;
        bus_l.serial_in    = si;
        bus_m.out_ready    = rdy;
        bus_l.out_ready    = rdy;
        flush              = fl;
        @(posedge clk);
        model_edge(sv, si, rdy, fl);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy);
        for (int i = 7; i >= 0; i--) step(1'b1, w[i], rdy, 1'b0);
    endtask

    // Asynchronous pulse between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_valid", 32'(bus_m.out_valid), 0);
        check("rst_count", 32'(bus_m.bit_count), 0);
        check("rst_ovr", 32'(bus_m.overrun), 0);
        check("rst_word", 32'(bus_m.parallel_out), 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] stream;
        stream = 8'h1E;
        rst    = 1'b1;
        flush  = 1'b0;
        bus_m.serial_valid = 1'b0;
        bus_l.serial_valid = 1'b0;
        bus_m.serial_in    = 1'b0;
        bus_l.serial_in    = 1'b0;
        bus_m.out_ready    = 1'b0;
        bus_l.out_ready    = 1'b0;
        model_reset();
        #12;
        rst = 1'b0;

        // Bit order, both instances, ready held high.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, stream[7-i], 1'b1, 1'b0);
            check("order_count", 32'(bus_m.bit_count), (i + 1) % 8);
            if (i < 7) check("order_novalid", 32'(bus_m.out_valid), 0);
        end
        check("order_valid", 32'(bus_m.out_valid), 1);
        check("order_msb", 32'(bus_m.parallel_out), 32'h1E);
        check("order_lsb", 32'(bus_l.parallel_out), 32'h78);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("order_one_cycle", 32'(bus_m.out_valid), 0);

        // Gaps on serial_valid with back-pressure for 20 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, stream[7-i], 1'b0, 1'b0);
            step(1'b0, ~stream[7-i], 1'b0, 1'b0);
            check("gap_count", 32'(bus_m.bit_count), (i + 1) % 8);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check("gap_hold_valid", 32'(bus_m.out_valid), 1);
            check("gap_hold_word", 32'(bus_m.parallel_out), 32'h1E);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("gap_drain", 32'(bus_m.out_valid), 0);

        // Overrun: second word dropped while the first is still held.
        do_reset();
        send_word(8'h1E, 1'b0);
        send_word(8'hFF, 1'b0);
        check("ovr_flag", 32'(bus_m.overrun), 1);
        check("ovr_keep_m", 32'(bus_m.parallel_out), 32'h1E);
        check("ovr_keep_l", 32'(bus_l.parallel_out), 32'h78);
        check("ovr_valid", 32'(bus_m.out_valid), 1);

        // Flush mid-word with serial_valid high clears everything, including overrun.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("flush_pre_count", 32'(bus_m.bit_count), 5);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("flush_count", 32'(bus_m.bit_count), 0);
        check("flush_valid", 32'(bus_m.out_valid), 0);
        check("flush_ovr", 32'(bus_m.overrun), 0);
        send_word(8'h1E, 1'b1);
        check("flush_word", 32'(bus_m.parallel_out), 32'h1E);
        check("flush_word_valid", 32'(bus_m.out_valid), 1);

        // Pass-through: ready arrives on exactly the completing edge of the second word.
        do_reset();
        send_word(8'h1E, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("pass_ovr", 32'(bus_m.overrun), 0);
        check("pass_word_m", 32'(bus_m.parallel_out), 32'hFF);
        check("pass_word_l", 32'(bus_l.parallel_out), 32'hFF);
        check("pass_valid", 32'(bus_m.out_valid), 1);

        // Asynchronous reset mid-word while a word is held.
        do_reset();
        send_word(8'h1E, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("areset_pre_valid", 32'(bus_m.out_valid), 1);
        check("areset_pre_count", 32'(bus_m.bit_count), 3);
        #2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, stream[7-i], 1'b0, 1'b0);
            if (i < 7) check("areset_partial", 32'(bus_m.out_valid), 0);
        end
        check("areset_full", 32'(bus_m.out_valid), 1);
        check("areset_word", 32'(bus_l.parallel_out), 32'h78);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Parametrised serial-to-parallel deserialiser. It is the successor to the fixed 4-bit SIPO and is generalised in word width and bit order. It adds four things: a bit-valid strobe, a bit counter, a one-word output holding register with a valid/ready handshake, and overrun detection. It sits between a serial bit source (line receiver, shift link) and word-wide downstream logic.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 means the first received bit lands in parallel_out[WIDTH-1] (matches the previous 4-bit SIPO); 0 means the first received bit lands in parallel_out[0].
- CNT_W, $clog2(WIDTH+1), local parameter (not overridable); width of bit_count.

Ports:
- clk  in  1  single clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the partial word, holding register and overrun flag.
- serial_in  in  1  serial data bit.
- serial_valid  in  1  serial_in is sampled on an edge where this is 1.
- parallel_out  out  WIDTH  assembled word from the holding register.
- out_valid  out  1  holding register is full.
- out_ready  in  1  consumer accepts the word on an edge where out_valid && out_ready.
- bit_count  out  CNT_W  number of bits of the current partial word, range 0..WIDTH-1.
- overrun  out  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset: assertion of rst immediately clears the shift register, bit_count, parallel_out, out_valid and overrun to 0. There is no clock dependency, and reset takes effect mid-word as well.
- Priority at each edge, highest first: rst, then flush, then normal operation.
- flush=1: shift register, bit_count, out_valid, parallel_out and overrun all go to 0. serial_valid on the same edge is ignored.
- Bit accept (serial_valid=1, flush=0):
  - MSB_FIRST=1: shift left and insert serial_in at bit 0.
  - MSB_FIRST=0: shift right and insert serial_in at bit WIDTH-1.
  - bit_count increments.
- serial_valid=0: shift register and bit_count hold.
- Word completion is an accepted bit while bit_count == WIDTH-1.
  - Completed word = current shift contents combined with the incoming bit, formed combinationally on that edge.
  - bit_count wraps to 0 on the same edge.
- Holding register free: it is free if out_valid=0, or if out_valid && out_ready on the same edge (pass-through).
  - If free at completion: parallel_out <= completed word and out_valid <= 1.
  - Latency: out_valid is high in the cycle after the edge that accepted the last bit.
- Holding register not free at completion (out_valid=1, out_ready=0):
  - The completed word is discarded and overrun <= 1.
  - The held word and out_valid are unchanged.
  - bit_count still wraps to 0.
- Handshake without completion: out_valid && out_ready clears out_valid to 0. parallel_out keeps its last value, which is don't-care while out_valid=0.
- Stability: while out_valid=1 and out_ready=0, parallel_out and out_valid are stable.
- overrun stays at 1 until rst or flush.
- Throughput: one bit per clock when serial_valid is held high, i.e. one word every WIDTH clocks. There is no back-pressure toward the serial side.

Decomposition:
- Package sipo_pkg holds:
  - the DEFAULT_WIDTH constant (8);
  - the bit-order enum type (SIPO_LSB_FIRST=0, SIPO_MSB_FIRST=1) used to drive MSB_FIRST.
- One sub-module, sipo_out_buf: a WIDTH-parameterised one-entry valid/ready holding register.
  - Inputs: load, load_data, out_ready, flush.
  - Outputs: parallel_out, out_valid, full_drop (full_drop feeds the overrun logic).
- The top level holds the shift register, bit counter and overrun flag.

Test Plan:
- Order, MSB first: WIDTH=8, MSB_FIRST=1, out_ready=1, serial_valid held 1, bits 0,0,0,1,1,1,1,0 -> out_valid high for exactly one cycle after the 8th edge, parallel_out=0x1E, bit_count sequence 1..7 then 0.
- Order, LSB first: MSB_FIRST=0, same bit stream -> parallel_out=0x78.
- Gaps and back-pressure:
  - Stimulus: same 0x1E stream (MSB_FIRST=1), serial_valid toggling 1/0 per cycle, out_ready=0 for 20 cycles.
  - Response: bits are taken only on valid edges; out_valid rises after the 8th accepted bit; parallel_out holds 0x1E steady until out_ready=1, and out_valid drops on that edge.
- Overrun and pass-through:
  - Stimulus: out_ready=0, send word 0x1E and then word 0xFF.
  - Response: overrun=1 after the 16th bit; parallel_out stays 0x1E.
  - Stimulus: repeat from reset with out_ready=1 asserted exactly on the 16th-bit edge.
  - Response: overrun=0, parallel_out=0xFF, out_valid stays 1.
- Flush mid-word: after 5 bits, assert flush one cycle together with serial_valid=1 -> bit_count=0, out_valid=0, overrun=0; the next 8 bits 0,0,0,1,1,1,1,0 give 0x1E.
- Asynchronous reset: assert rst between clock edges after 3 bits with out_valid=1 -> all outputs are 0 before the next edge; after release, a full 8-bit word is required for out_valid.
